alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, registered successor to the CPU's combinational 8-bit ALU.
- Keeps the existing 8 opcodes, adds serial shifts and an optional shift-add multiplier, and registers results and flags behind a start/busy/done handshake.
- Sits between the register file and the accumulator/flag register. The control FSM issues one op at a time and waits for done.

Parameters:
- WIDTH, 8, operand/result width in bits (≥4).
- SHW, $clog2(WIDTH), width of the shift-amount field taken from b[SHW-1:0].

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request; accepted only when busy=0
- a  input  WIDTH  operand A, sampled on accept
- b  input  WIDTH  operand B / shift amount, sampled on accept
- op  input  4  opcode, sampled on accept
- busy  output  1  high from the cycle after accept until the cycle done pulses (inclusive)
- done  output  1  one-cycle pulse when res/flags update
- res  output  WIDTH  registered result, held until next done
- c_out  output  1  carry/borrow/shift-out flag
- zero  output  1  res==0
- ovf  output  1  signed overflow / mul overflow
- neg  output  1  res[WIDTH-1]

Behaviour:
- Reset: one clock, synchronous, active-high (clk, rst). rst=1 at a rising edge → state IDLE, busy=0, done=0, res=0, c_out=0, zero=0, ovf=0, neg=0, internal counters/operand regs cleared. Aborts any in-flight op with no done pulse.
- Accept: start=1 && busy=0 at an edge latches a, b, op. start while busy=1 is ignored (not queued).
- Opcodes:
  - 0000 AND, 0001 OR, 0010 XOR, 0011 NOT a
  - 0100 ADD a+b; 0101 SUB a-b; 0110 INC a+1; 0111 DEC a-1
  - 1000 SHL, 1001 SHR logical, 1010 ASR, each by b[SHW-1:0]
  - 1011 MUL low half; 1100 MULH high half (unsigned)
  - 1101-1111 illegal
- Single-cycle ops (0000-0111, illegal): FSM stays IDLE. res/flags written and done=1 on the edge after accept (latency 1). busy never rises. A new start may be accepted in the same cycle done is high.
- Shifts: state SHIFT, one bit per cycle, down-counter loaded with the shift amount.
  - done on the edge after the counter reaches 0; latency = shamt+1 cycles. shamt=0 → latency 1, res=a, c_out=0.
  - c_out = last bit shifted out.
  - ASR replicates the MSB.
- MUL/MULH: state MUL, shift-add over exactly WIDTH iterations into a 2·WIDTH accumulator; latency WIDTH+1. MUL returns the low half, MULH the high half.
- States: IDLE → SHIFT (shift op, shamt>0) | MUL (mul op) → IDLE with done. All other ops stay in IDLE.
- Arithmetic width: all ops WIDTH-bit with wrap-around.
- Flags, updated only when done pulses:
  - ADD/INC: c_out = unsigned carry out.
  - SUB/DEC: c_out = borrow (a<b, or a==0 for DEC).
  - ADD/SUB/INC/DEC: ovf = two's-complement signed overflow.
  - Logic ops and shifts: ovf=0. Logic ops: c_out=0.
  - MUL: c_out=ovf=(high half ≠0). MULH: c_out=ovf=0.
  - Illegal opcode: res=0, c_out=0, ovf=0, zero=1, neg=0.
  - zero/neg always derive from the new res.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: opcodes 1011/1100 behave as above; the MUL state and the 2·WIDTH accumulator exist.
- Undefined: no multiplier logic; 1011/1100 are treated as illegal (latency 1, res=0, zero=1).

Test Plan:
- Legacy ops, WIDTH=8:
  - AND 0xCC,0xAA → 0x88; OR → 0xEE; XOR → 0x66; NOT 0x0F → 0xF0.
  - 99 INC → 100; 5 DEC → 4.
  - Each op: done exactly 1 cycle after start, busy stays 0.
- Flags:
  - ADD 200+100 → res 44, c_out=1, ovf=0.
  - ADD 100+50 → 150, ovf=1, neg=1.
  - SUB 40-100 → 196, c_out=1.
  - SUB 7-7 → 0, zero=1.
  - DEC 0 → 255, c_out=1.
- Shifts:
  - SHL 0x81 by 3 → 0x08, c_out=0, done 4 cycles after start.
  - ASR 0x80 by 2 → 0xE0.
  - SHR 0x01 by 1 → 0x00, c_out=1, zero=1.
  - shamt 0 → res=a, latency 1.
- Multiply (macro defined):
  - MUL 20×13 → res 4, c_out=ovf=1, done 9 cycles after start.
  - MULH 20×13 → 1.
  - Macro undefined: MUL → res 0, zero=1, latency 1.
- Handshake/reset:
  - start with a different op while MUL is busy → ignored; original result delivered.
  - rst=1 mid-SHIFT → next edge busy=0, res=0, all flags 0, no done pulse.
  - New op accepted the following cycle.
- Illegal opcode 1111 → res 0, zero=1, done after 1 cycle.

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with serial shifts, optional multiplier and start/busy/done handshake
// Purpose: successor to the combinational 8-bit ALU. Logic and add/sub ops finish in one
//   cycle. Shifts move one bit per cycle. MUL/MULH run a shift-add loop over WIDTH cycles.
//   Result and flags are registered and change only when done pulses.
// Optional feature macro: ALU_SEQ_MUL_EN. When it is defined, opcodes 1011/1100 are
//   MUL/MULH. When it is not defined, those opcodes are treated as illegal.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request; accepted only while busy=0
//   a, b   in   operands (b[SHW-1:0] is the shift amount), sampled on accept
//   op     in   4-bit opcode, sampled on accept
//   busy   out  multi-cycle op in flight, including its done cycle
//   done   out  one-cycle pulse when res/flags update
//   res    out  registered result
//   c_out, zero, ovf, neg  out  registered flags

module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             c_out,
  output logic             zero,
  output logic             ovf,
  output logic             neg
);

  localparam int CW  = $clog2(WIDTH + 1);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL} state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_val;
  logic [3:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_done, r_c, r_z, r_v, r_n;
  logic [WIDTH-1:0] r_res;

  logic             w_accept, w_is_shift, w_is_mul, w_multi, w_last;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH:0]   w_add, w_sub, w_inc, w_dec;
  logic [WIDTH-1:0] w_sc_res, w_step_val, w_fin_res, w_wr_res;
  logic             w_sc_c, w_sc_v, w_step_out, w_fin_c, w_fin_v;
  logic             w_wr_en, w_wr_c, w_wr_v;

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0]   r_mb;
  logic [2*WIDTH-1:0] r_mcand, r_acc, w_acc_next;
  assign w_is_mul   = (op == 4'b1011) || (op == 4'b1100);
  assign w_acc_next = r_acc + (r_mb[0] ? r_mcand : '0);
`else
  assign w_is_mul   = 1'b0;
`endif

  assign w_accept   = start && (r_state == S_IDLE);
  assign w_shamt    = b[SHW-1:0];
  assign w_is_shift = (op == 4'b1000) || (op == 4'b1001) || (op == 4'b1010);
  // A zero-length shift completes in IDLE like any single-cycle op.
  assign w_multi    = w_is_mul || (w_is_shift && (w_shamt != '0));
  // Final iteration: the counter is about to reach zero, so results are written now.
  assign w_last     = (r_state != S_IDLE) && (r_cnt == CW'(1));

  // Top bit of each extended sum is the carry (add) or the borrow (subtract).
  assign w_add = {1'b0, a} + {1'b0, b};
  assign w_sub = {1'b0, a} - {1'b0, b};
  assign w_inc = {1'b0, a} + (WIDTH + 1)'(1);
  assign w_dec = {1'b0, a} - (WIDTH + 1)'(1);

  always_comb begin
    w_sc_res = '0;
    w_sc_c   = 1'b0;
    w_sc_v   = 1'b0;
    case (op)
      4'b0000: w_sc_res = a & b;
      4'b0001: w_sc_res = a | b;
      4'b0010: w_sc_res = a ^ b;
      4'b0011: w_sc_res = ~a;
      4'b0100: begin
        w_sc_res = w_add[MSB:0];
        w_sc_c   = w_add[WIDTH];
        w_sc_v   = (a[MSB] == b[MSB]) && (w_add[MSB] != a[MSB]);
      end
      4'b0101: begin
        w_sc_res = w_sub[MSB:0];
        w_sc_c   = w_sub[WIDTH];
        w_sc_v   = (a[MSB] != b[MSB]) && (w_sub[MSB] != a[MSB]);
      end
      4'b0110: begin
        w_sc_res = w_inc[MSB:0];
        w_sc_c   = w_inc[WIDTH];
        w_sc_v   = !a[MSB] && w_inc[MSB];
      end
      4'b0111: begin
        w_sc_res = w_dec[MSB:0];
        w_sc_c   = w_dec[WIDTH];
        w_sc_v   = a[MSB] && !w_dec[MSB];
      end
      4'b1000, 4'b1001, 4'b1010: w_sc_res = a;
      default: ;
    endcase
  end

  // One shift step on the working value. The bit that falls off becomes the carry.
  always_comb begin
    w_step_val = r_val;
    w_step_out = 1'b0;
    case (r_op)
      4'b1000: {w_step_out, w_step_val} = {r_val, 1'b0};
      4'b1001: {w_step_val, w_step_out} = {1'b0, r_val};
      4'b1010: {w_step_val, w_step_out} = {r_val[MSB], r_val};
      default: ;
    endcase
  end

  always_comb begin
    w_fin_res = w_step_val;
    w_fin_c   = w_step_out;
    w_fin_v   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    if (r_state == S_MUL) begin
      if (r_op == 4'b1011) begin
        w_fin_res = w_acc_next[MSB:0];
        w_fin_c   = |w_acc_next[2*WIDTH-1:WIDTH];
        w_fin_v   = |w_acc_next[2*WIDTH-1:WIDTH];
      end else begin
        w_fin_res = w_acc_next[2*WIDTH-1:WIDTH];
        w_fin_c   = 1'b0;
      end
    end
`endif
  end

  // Accept only occurs in IDLE and w_last only outside it, so the two never coincide.
  always_comb begin
    w_wr_en  = (w_accept && !w_multi) || w_last;
    w_wr_res = w_last ? w_fin_res : w_sc_res;
    w_wr_c   = w_last ? w_fin_c : w_sc_c;
    w_wr_v   = w_last ? w_fin_v : w_sc_v;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mul) begin
          w_state_next = S_MUL;
        end else if (w_accept && w_multi) begin
          w_state_next = S_SHIFT;
        end
      end
      // The state is held for one cycle after the final write so that busy covers the done cycle.
      S_SHIFT, S_MUL: if (r_cnt == '0) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_val  <= '0;
      r_op   <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_res  <= '0;
      r_c    <= 1'b0;
      r_z    <= 1'b0;
      r_v    <= 1'b0;
      r_n    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      r_mb    <= '0;
      r_mcand <= '0;
      r_acc   <= '0;
`endif
    end else begin
      r_done <= w_wr_en;
      if (w_wr_en) begin
        r_res <= w_wr_res;
        r_c   <= w_wr_c;
        r_v   <= w_wr_v;
        r_z   <= (w_wr_res == '0);
        r_n   <= w_wr_res[MSB];
      end
      if (w_accept) begin
        r_op  <= op;
        r_val <= a;
        r_cnt <= w_is_mul ? CW'(WIDTH) : (w_is_shift ? CW'(w_shamt) : '0);
`ifdef ALU_SEQ_MUL_EN
        r_acc   <= '0;
        r_mcand <= {{WIDTH{1'b0}}, a};
        r_mb    <= b;
`endif
      end else if ((r_state != S_IDLE) && (r_cnt != '0)) begin
        r_val <= w_step_val;
        r_cnt <= r_cnt - CW'(1);
`ifdef ALU_SEQ_MUL_EN
        r_acc   <= w_acc_next;
        r_mcand <= r_mcand << 1;
        r_mb    <= r_mb >> 1;
`endif
      end
    end
  end

  assign busy  = (r_state != S_IDLE);
  assign done  = r_done;
  assign res   = r_res;
  assign c_out = r_c;
  assign zero  = r_z;
  assign ovf   = r_v;
  assign neg   = r_n;

endmodule
